crossbar_arb2: RTL and testbench

- Two-requester packet arbiter that sequences the 2:1 crossbar datapath mux.
- Picks one of two valid/ready streams, locks the grant for a whole packet (until the LAST beat), then releases.
- Drives the mux select S and the downstream handshake.
- Data never passes through this block: data goes X0/X1 -> MUX2 -> Y, and only control is handled here.

---
 rtl/crossbar_arb2.sv | 118 +++++++++++
 tb/tb_crossbar_arb2.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/crossbar_arb2.sv
// Two-requester packet arbiter that drives the select and handshake of a 2:1 crossbar mux.
// The grant is locked for a whole packet; priority alternates between packets for fairness.
module crossbar_arb2 #(
  parameter int Count_Width = 8,
  parameter int Max_Beats   = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   VALID0,
  input  logic                   LAST0,
  output logic                   READY0,
  input  logic                   VALID1,
  input  logic                   LAST1,
  output logic                   READY1,
  output logic                   Y_VALID,
  output logic                   Y_LAST,
  input  logic                   Y_READY,
  output logic                   S,
  output logic                   BUSY,
  output logic [Count_Width-1:0] BEATS,
  output logic                   ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  // One extra bit so the limit compare cannot wrap at 2^Count_Width-1.
  localparam logic [Count_Width:0] MAX_B = (Count_Width+1)'(Max_Beats);

  state_t                 state_q, state_d;
  logic                   s_q, s_d;
  logic                   prio_q, prio_d;
  logic                   err_q, err_d;
  logic [Count_Width-1:0] beats_q, beats_d;
  logic [Count_Width:0]   beats_inc;
  logic                   sel, cur_valid, cur_last;

  assign beats_inc = {1'b0, beats_q} + (Count_Width+1)'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    prio_d    = prio_q;
    beats_d   = beats_q;
    err_d     = 1'b0;
    READY0    = 1'b0;
    READY1    = 1'b0;
    Y_VALID   = 1'b0;
    Y_LAST    = 1'b0;
    sel       = 1'b0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (VALID0 && VALID1) begin
          s_d     = prio_q;
          state_d = prio_q ? LOCK1 : LOCK0;
        end else if (VALID0) begin
          s_d     = 1'b0;
          state_d = LOCK0;
        end else if (VALID1) begin
          s_d     = 1'b1;
          state_d = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        sel       = (state_q == LOCK1);
        cur_valid = sel ? VALID1 : VALID0;
        cur_last  = sel ? LAST1 : LAST0;
        Y_VALID   = cur_valid;
        Y_LAST    = cur_last;
        READY0    = !sel && Y_READY;
        READY1    = sel && Y_READY;
        if (cur_valid && Y_READY) begin
          // LAST wins over the beat limit, so a LAST beat at the limit is a clean end.
          if (cur_last) begin
            state_d = IDLE;
            prio_d  = ~sel;
            beats_d = '0;
          end else if (beats_inc == MAX_B) begin
            state_d = IDLE;
            prio_d  = ~sel;
            beats_d = '0;
            err_d   = 1'b1;
          end else begin
            beats_d = beats_inc[Count_Width-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign S     = s_q;
  assign BUSY  = (state_q != IDLE);
  assign BEATS = beats_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_crossbar_arb2.sv
// Directed bench for crossbar_arb2 with a 4-beat limit: vector table plus async-reset sequence.
module tb_crossbar_arb2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       VALID0, LAST0, READY0;
  logic       VALID1, LAST1, READY1;
  logic       Y_VALID, Y_LAST, Y_READY;
  logic       S, BUSY, ERR;
  logic [7:0] BEATS;

  int checks = 0;
  int errors = 0;

  crossbar_arb2 #(.Count_Width(8), .Max_Beats(4)) dut (
    .CLK(CLK), .RST(RST),
    .VALID0(VALID0), .LAST0(LAST0), .READY0(READY0),
    .VALID1(VALID1), .LAST1(LAST1), .READY1(READY1),
    .Y_VALID(Y_VALID), .Y_LAST(Y_LAST), .Y_READY(Y_READY),
    .S(S), .BUSY(BUSY), .BEATS(BEATS), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, v0, l0, v1, l1, yr;
    logic       r0, r1, yv, yl, s, busy;
    logic [7:0] beats;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, v0, l0, v1, l1, yr,
                     input logic r0, r1, yv, yl, s, busy,
                     input logic [7:0] beats, input logic err);
    vec_t t;
    t.rst = rst; t.v0 = v0; t.l0 = l0; t.v1 = v1; t.l1 = l1; t.yr = yr;
    t.r0 = r0; t.r1 = r1; t.yv = yv; t.yl = yl; t.s = s; t.busy = busy;
    t.beats = beats; t.err = err;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v0, l0, v1, l1, yr);
    VALID0 = v0; LAST0 = l0; VALID1 = v1; LAST1 = l1; Y_READY = yr;
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 0, 0, 0, 0);

    //   rst v0 l0 v1 l1 yr | r0 r1 yv yl s busy beats err
    // single requester, 3-beat packet
    add(0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 1, 0, 0, 1,   1, 0, 1, 1, 0, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    // reset to clear priority, then contention with 2-beat packets: 0,1,0,1
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 1,   1, 0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1,   0, 1, 1, 0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 1, 1,   0, 1, 1, 1, 1, 1, 1, 0);
    add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 1,   1, 0, 1, 1, 0, 1, 1, 0);
    add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1,   0, 1, 1, 0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 1, 1,   0, 1, 1, 1, 1, 1, 1, 0);
    // backpressure on LOCK1, Y_READY 1,0,0,1
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1,   0, 1, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 1,   0, 1, 1, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
    // forced release after 4 beats without LAST, requester 1 pending
    add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 1, 2, 0);
    add(0, 1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 1, 3, 0);
    add(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 1, 1,   0, 1, 1, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
    // LAST exactly at the limit, with an idle-valid stall in the middle
    add(0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 2, 0);
    add(0, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 1, 2, 0);
    add(0, 1, 1, 0, 0, 1,   1, 0, 1, 1, 0, 1, 3, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_s", -1, {7'd0, S}, 8'd0);
    chk("rst_busy", -1, {7'd0, BUSY}, 8'd0);
    chk("rst_beats", -1, BEATS, 8'd0);
    chk("rst_err", -1, {7'd0, ERR}, 8'd0);
    RST = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge CLK);
      #1;
      RST = tbl[i].rst;
      drive(tbl[i].v0, tbl[i].l0, tbl[i].v1, tbl[i].l1, tbl[i].yr);
      @(negedge CLK);
      chk("ready0", i, {7'd0, READY0}, {7'd0, tbl[i].r0});
      chk("ready1", i, {7'd0, READY1}, {7'd0, tbl[i].r1});
      chk("y_valid", i, {7'd0, Y_VALID}, {7'd0, tbl[i].yv});
      chk("y_last", i, {7'd0, Y_LAST}, {7'd0, tbl[i].yl});
      chk("s", i, {7'd0, S}, {7'd0, tbl[i].s});
      chk("busy", i, {7'd0, BUSY}, {7'd0, tbl[i].busy});
      chk("beats", i, BEATS, tbl[i].beats);
      chk("err", i, {7'd0, ERR}, {7'd0, tbl[i].err});
    end

    // Async reset mid-packet on LOCK1 (priority is 1 here), then check priority was cleared.
    @(posedge CLK);
    #1;
    drive(0, 0, 1, 0, 1);
    @(posedge CLK);
    #1;
    chk("pre_s", 100, {7'd0, S}, 8'd1);
    chk("pre_busy", 100, {7'd0, BUSY}, 8'd1);
    @(posedge CLK);
    #1;
    chk("pre_beats", 101, BEATS, 8'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_s", 102, {7'd0, S}, 8'd0);
    chk("arst_busy", 102, {7'd0, BUSY}, 8'd0);
    chk("arst_beats", 102, BEATS, 8'd0);
    chk("arst_err", 102, {7'd0, ERR}, 8'd0);
    chk("arst_ready1", 102, {7'd0, READY1}, 8'd0);
    chk("arst_y_valid", 102, {7'd0, Y_VALID}, 8'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(1, 0, 1, 0, 1);
    @(posedge CLK);
    #1;
    chk("post_s", 103, {7'd0, S}, 8'd0);
    chk("post_busy", 103, {7'd0, BUSY}, 8'd1);
    chk("post_ready0", 103, {7'd0, READY0}, 8'd1);
    chk("post_ready1", 103, {7'd0, READY1}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
